uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte interface (start/byte/busy/done) between NUM_REQ client channels.
- Round-robin arbitration at packet granularity. A granted client keeps the transmitter until it flags its last byte, so packets never interleave on the serial line.
- Sits between the application clients and the UART TX serializer, in the same clock domain as the UART RX/TX blocks (10 MHz, 115200 baud).

Parameters:
- NUM_REQ, 4, number of client channels (2..8).
- ID_W, 2, width of the grant index; must be at least ceil(log2(NUM_REQ)).
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles for one byte (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-client request; must stay high while the client has a byte pending.
- req_data  in  8*NUM_REQ  client i byte on bits [8i+7:8i].
- req_last  in  NUM_REQ  client i current byte is the last byte of its packet.
- ack  out  NUM_REQ  one-hot, one-cycle pulse: client's byte was consumed; the client presents its next byte the following cycle.
- tx_start  out  1  one-cycle pulse to the serializer.
- tx_byte  out  8  byte for the serializer, valid and held from the tx_start cycle.
- tx_busy  in  1  serializer is shifting.
- tx_done  in  1  one-cycle pulse at the end of the stop bit.
- grant_valid  out  1  a client owns the transmitter.
- grant_id  out  ID_W  index of the owning client.
- err_timeout  out  1  sticky watchdog error; constant 0 without the optional feature.

Behaviour:
- Reset values (async assert): tx_start=0, tx_byte=0, ack=0, grant_valid=0, grant_id=0, err_timeout=0, rr_ptr=0, state=IDLE. Any in-flight packet is abandoned. The release edge is synchronised internally.
- All outputs are registered.
- Arbitration: scan from rr_ptr upward with wrap-around (NUM_REQ-1 wraps to 0); the first req bit found wins. rr_ptr becomes winner+1 (mod NUM_REQ) when the packet ends.
- FSM IDLE: if any req bit is set, latch the winner into grant_id, set grant_valid=1, go to LOAD. Otherwise stay.
- FSM LOAD:
  - If req[grant_id]=0 (client withdrew): grant_valid=0, advance rr_ptr, go to IDLE. No tx_start is issued.
  - Otherwise, when tx_busy=0: pulse tx_start and ack[grant_id] for one cycle, register tx_byte=req_data[grant_id], latch last_q=req_last[grant_id], go to WAIT_DONE.
  - While tx_busy=1: stay in LOAD.
- FSM WAIT_DONE: on tx_done:
  - If last_q=1: grant_valid=0, advance rr_ptr, go to IDLE.
  - Otherwise go to LOAD (same owner, locked).
- Latency: req rises in IDLE at edge N, with tx_busy=0 → tx_start high after edge N+2. Back-to-back bytes inside a packet: tx_start follows tx_done by 2 cycles.
- Simultaneous events:
  - A req change on the cycle tx_done arrives is evaluated in the next LOAD.
  - Requests from non-owners are ignored until IDLE.
  - Two requesters rising in the same cycle: round-robin decides.
- tx_done received outside WAIT_DONE is ignored.
- A single-byte packet (req_last=1 on the first byte) releases the grant after one tx_done.

Optional Feature:
- Macro: UART_TX_ARB_WDOG_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_DONE and increments each cycle there.
  - On reaching TIMEOUT_CYCLES without tx_done: err_timeout=1 (sticky until rst), grant released, rr_ptr advanced, go to IDLE.
- Undefined: no counter is built, err_timeout is tied to 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Package uart_pkg: FSM state encoding (IDLE, LOAD, WAIT_DONE, 2-bit), CLKS_PER_BIT=87, byte width constant 8.
- One sub-module: rr_pick. It is combinational: inputs req vector and rr_ptr, outputs winner index and any_req. It is instantiated once and reusable by future arbiters.

Test Plan:
- Single client: req[0]=1, req_data=8'hA5, req_last=1 with tx_busy=0 → tx_start plus ack[0] after edge N+2 with tx_byte=8'hA5; grant released one cycle after tx_done; rr_ptr=1.
- Packet lock: client 1 sends 3 bytes 8'h11/22/33 (last on 33) while req[2]=1 throughout → exactly 3 tx_start pulses with grant_id=1, then grant_id=2.
- Round-robin fairness: req=4'b1111, each client sending single-byte packets → grant order 0,1,2,3,0.
- Withdraw: req[3] drops while in LOAD with tx_busy=1 → no tx_start, grant_valid=0, next grant goes to the next requester.
- Reset mid-packet: assert rst during WAIT_DONE of client 2's second byte → all outputs 0 immediately; after release, req[2] restarts from rr_ptr=0 arbitration.
- With UART_TX_ARB_WDOG_EN and TIMEOUT_CYCLES=64: withhold tx_done → err_timeout=1 at cycle 64 and grant released; without the macro, err_timeout stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//
// Contents:
//   BYTE_W       - width of one UART data byte
//   CLKS_PER_BIT - baud divider for 115200 baud from a 10 MHz clock
//   arb_state_e  - encoding of the transmit arbiter FSM
package uart_pkg;

  localparam int BYTE_W       = 8;
  localparam int CLKS_PER_BIT = 87;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the application clients, the transmit arbiter and
// the UART TX serializer.
//
// Parameters: NUM_REQ client channels, ID_W bits of grant index.
// Modports:
//   master - the arbiter: consumes client requests and serializer status,
//            drives ack, tx_start/tx_byte, grant status and debug state.
//   slave  - the environment: clients plus serializer.
//
// Handshakes:
//   Client side: req[i] is the valid for byte req_data[8i+7:8i] (with
//   req_last[i]); it must be held with stable data until ack[i] pulses for
//   one cycle, which means the byte was taken. The client shows its next
//   byte (or drops req[i]) from the cycle after ack.
//   Serializer side: tx_busy low is the ready; tx_start pulses for one cycle
//   only while ready, and tx_byte stays valid from that cycle until the next
//   tx_start. tx_done is a one-cycle completion pulse.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        ack;
  logic                      tx_start;
  logic [BYTE_W-1:0]         tx_byte;
  logic                      tx_busy;
  logic                      tx_done;
  logic                      grant_valid;
  logic [ID_W-1:0]           grant_id;
  logic                      err_timeout;
  arb_state_e                dbg_state;
  logic [ID_W-1:0]           dbg_rr_ptr;

  modport master (
    input  req, req_data, req_last, tx_busy, tx_done,
    output ack, tx_start, tx_byte, grant_valid, grant_id, err_timeout,
           dbg_state, dbg_rr_ptr
  );

  modport slave (
    output req, req_data, req_last, tx_busy, tx_done,
    input  ack, tx_start, tx_byte, grant_valid, grant_id, err_timeout,
           dbg_state, dbg_rr_ptr
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//
// Scans req starting at rr_ptr and moving upward with wrap-around; the first
// set bit wins. rr_ptr must be below NUM_REQ.
//
// Ports:
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  ID_W     highest-priority index for this scan
//   winner  out ID_W     index of the selected requester (0 when none)
//   any_req out 1        at least one request is set
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  always_comb begin
    int              pos;
    logic [ID_W-1:0] idx;
    winner  = '0;
    any_req = 1'b0;
    pos     = 0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(rr_ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = ID_W'(pos);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX serializer between NUM_REQ clients
// with round-robin arbitration at packet granularity. The owner keeps the
// serializer until its byte flagged last completes, so packets never
// interleave on the line.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset; release is synchronised inside
//   bus  - uart_tx_arbiter_if.master (client req/data/last/ack, serializer
//          start/byte/busy/done, grant_valid/grant_id, err_timeout, plus
//          dbg_state/dbg_rr_ptr exposing the FSM state and rr pointer)
//
// Optional feature, macro UART_TX_ARB_WDOG_EN: a per-byte watchdog in
// WAIT_DONE. After TIMEOUT_CYCLES cycles without tx_done it sets the sticky
// err_timeout and releases the grant. Without the macro err_timeout is 0 and
// WAIT_DONE waits indefinitely.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (ID_W < $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W too narrow for NUM_REQ");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  // Reset asserts immediately but releases two clock edges after rst falls,
  // so every flop leaves reset on the same edge.
  logic [1:0] rst_sync_q;
  logic       rst_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_i = rst_sync_q[1];

  // Per-client byte lanes as an array so the owner's byte is a plain index.
  logic [BYTE_W-1:0] data_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign data_arr[g] = bus.req_data[BYTE_W*g +: BYTE_W];
  end

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              grant_valid_q, grant_valid_d;
  logic              tx_start_q, tx_start_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic              last_q, last_d;
  logic [ID_W-1:0]   winner;
  logic              any_req;
`ifdef UART_TX_ARB_WDOG_EN
  logic [15:0]       wdog_q, wdog_d;
  logic              err_q, err_d;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // The client after the one releasing the grant gets first look next time.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) return '0;
    return id + ID_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_byte_q     <= '0;
      ack_q         <= '0;
      last_q        <= 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
      wdog_q        <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      tx_start_q    <= tx_start_d;
      tx_byte_q     <= tx_byte_d;
      ack_q         <= ack_d;
      last_q        <= last_d;
`ifdef UART_TX_ARB_WDOG_EN
      wdog_q        <= wdog_d;
      err_q         <= err_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    tx_start_d    = 1'b0;
    tx_byte_d     = tx_byte_q;
    ack_d         = '0;
    last_d        = last_q;
`ifdef UART_TX_ARB_WDOG_EN
    wdog_d        = wdog_q;
    err_d         = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_id_d    = winner;
          grant_valid_d = 1'b1;
          state_d       = LOAD;
        end
      end

      LOAD: begin
        // A withdrawn request ends the packet even while the serializer is
        // still busy, so a stalled owner cannot hold the line.
        if (!bus.req[grant_id_q]) begin
          grant_valid_d = 1'b0;
          rr_ptr_d      = next_ptr(grant_id_q);
          state_d       = IDLE;
        end else if (!bus.tx_busy) begin
          tx_start_d          = 1'b1;
          ack_d[grant_id_q]   = 1'b1;
          tx_byte_d           = data_arr[grant_id_q];
          last_d              = bus.req_last[grant_id_q];
          state_d             = WAIT_DONE;
`ifdef UART_TX_ARB_WDOG_EN
          wdog_d              = '0;
`endif
        end
      end

      WAIT_DONE: begin
        if (bus.tx_done) begin
          if (last_q) begin
            grant_valid_d = 1'b0;
            rr_ptr_d      = next_ptr(grant_id_q);
            state_d       = IDLE;
          end else begin
            state_d       = LOAD;
          end
        end
`ifdef UART_TX_ARB_WDOG_EN
        else if (wdog_q == 16'(TIMEOUT_CYCLES - 1)) begin
          err_d         = 1'b1;
          grant_valid_d = 1'b0;
          rr_ptr_d      = next_ptr(grant_id_q);
          state_d       = IDLE;
        end else begin
          wdog_d        = wdog_q + 16'd1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ack         = ack_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_rr_ptr  = rr_ptr_q;
`ifdef UART_TX_ARB_WDOG_EN
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

endmodule
